crossfile_packer: RTL and testbench
===================================

CROSSFILE_PACKER -- requirements
Module: crossfile_packer

Interface
REQ-001 The block SHALL have these parameters:
- DEPTH, default crossfile_pkg::FIFO_DEPTH, is the number of downstream buffer slots available as credits.
- BEAT_W, default 8, is the width of one input beat in bits.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports:
- clk, input, 1, sole clock; all logic on posedge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, block accepts a beat this cycle.
- in_data, input, BEAT_W, beat payload.
- in_last, input, 1, final beat of a transaction.
- out_valid, output, 1, single-cycle strobe: out_trans is valid this cycle.
- out_trans, output, transaction_t, assembled transaction feeding crossfile_user trans_in.
- credit_ret, input, 1, downstream freed one slot (one-cycle pulse).
- credits, output, $clog2(DEPTH+1), credits currently available.
- err_len, output, 1, one-cycle pulse on a framing error.

Function
REQ-003 The block SHALL define TRANS_W = $bits(transaction_t) and NBEATS = ceil(TRANS_W/BEAT_W).
- A beat transfers when in_valid and in_ready are both high in the same cycle.
REQ-004 Beat k (0-based) SHALL land in bits [k*BEAT_W +: BEAT_W] of the assembly register, LSB-first. Bits above TRANS_W in the last beat are discarded.
REQ-005 The FSM SHALL have four states with these transitions:
- IDLE: on the first beat, go to FILL (or to EMIT if NBEATS==1 and in_last).
- FILL: on a beat with count==NBEATS-1 and in_last, go to EMIT.
- EMIT: when credits>0, go to IDLE.
- DRAIN: on a beat with in_last, go to IDLE.
REQ-006 in_ready SHALL be high in IDLE, FILL and DRAIN, and low in EMIT.
REQ-007 In EMIT with credits>0, out_valid SHALL pulse for exactly one cycle, and credits SHALL decrement that cycle.
- Latency: last beat accepted in cycle t gives out_valid in cycle t+1 when credits>0.
REQ-008 In EMIT with credits==0, the FSM SHALL hold, out_valid SHALL stay low, and out_trans SHALL stay stable until a credit arrives.
REQ-009 out_trans SHALL hold its last emitted value between pulses.
REQ-010 An early in_last (count<NBEATS-1) SHALL pulse err_len for one cycle, discard the partial data, and return the FSM to IDLE.
REQ-011 A missing in_last on beat NBEATS-1 SHALL pulse err_len for one cycle and move the FSM to DRAIN. DRAIN discards beats until and including the in_last beat.
REQ-012 credit_ret SHALL increment credits by one.
- credit_ret and an emit in the same cycle SHALL leave credits unchanged.
- credit_ret with credits==DEPTH and no emit SHALL be ignored (saturate).
REQ-013 All counters SHALL be sized from the parameters. The beat counter SHALL be $clog2(NBEATS+1) bits wide and SHALL never wrap within a transaction.

Reset
REQ-014 With rst high at a clock edge, the block SHALL set:
- FSM to IDLE, beat count 0, assembly register 0.
- out_valid 0, out_trans '0, err_len 0, credits DEPTH.
- in_ready high from the first cycle after reset.
REQ-015 Reset asserted mid-transaction or in EMIT SHALL drop the pending transaction with no out_valid pulse.

Configuration
REQ-016 With CROSSFILE_PACKER_STATS_EN defined, the block SHALL add two outputs:
- pkt_count, 16-bit, increments on each out_valid and wraps 0xFFFF->0.
- err_count, 8-bit, increments on each err_len and saturates at 0xFF.
- Both reset to 0.
REQ-017 Without CROSSFILE_PACKER_STATS_EN, neither port nor its counters SHALL exist, and behaviour SHALL otherwise be identical.

Structure
REQ-018 crossfile_pkg SHALL hold:
- packer_state_e (IDLE, FILL, EMIT, DRAIN).
- PACKER_BEAT_W = 8.
- function calc_beats(int bits, int beat_w) returning the ceiling division.
- transaction_t and FIFO_DEPTH remain there as already defined.
REQ-019 Credit tracking SHALL be the sub-module crossfile_credit_ctr (params MAX; ports clk, rst, inc, dec, count), instantiated once.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then NBEATS beats 0x01,0x02,... with in_last on the final beat -> out_valid one cycle later; out_trans matches packed bytes LSB-first; credits = DEPTH-1.
- DEPTH back-to-back transactions with no credit_ret -> DEPTH pulses; the next transaction holds in EMIT with in_ready=0; one credit_ret -> pulse next cycle.
- in_last on beat 1 (NBEATS>2) -> err_len one cycle, no out_valid; the next clean transaction emits correctly.
- No in_last on beat NBEATS-1, then 3 extra beats with in_last on the third -> err_len once, no out_valid, FSM back in IDLE.
- credit_ret and emit in the same cycle -> credits unchanged; credit_ret at credits=DEPTH -> stays DEPTH.
- rst asserted after 2 beats -> no out_valid, credits = DEPTH; with STATS_EN, pkt_count = 0.

Source files
------------

// File: rtl/crossfile_pkg.sv
// Shared types and constants for the crossfile packer slice: transaction layout,
// downstream buffer depth, packer FSM states and a beat-count helper.
package crossfile_pkg;

  localparam int FIFO_DEPTH    = 4;
  localparam int PACKER_BEAT_W = 8;

  // 28-bit transaction, deliberately not a whole number of bytes
  typedef struct packed {
    logic [7:0]  tag;
    logic [15:0] addr;
    logic [3:0]  op;
  } transaction_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    EMIT,
    DRAIN
  } packer_state_e;

  function automatic int calc_beats(int bits, int beat_w);
    return (bits + beat_w - 1) / beat_w;
  endfunction

endpackage

// File: rtl/crossfile_credit_ctr.sv
// Saturating up/down credit counter; resets full (MAX) and treats a simultaneous
// increment and decrement as no change.
module crossfile_credit_ctr #(
  parameter int MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inc,
  input  logic                         dec,
  output logic [$clog2(MAX+1)-1:0]     count
);

  localparam int CW = $clog2(MAX + 1);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= CW'(MAX);
    end else if (inc && !dec && count != CW'(MAX)) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/crossfile_packer.sv
// Packs BEAT_W-bit beats LSB-first into a transaction_t for crossfile_user trans_in,
// gated by downstream credits. Define CROSSFILE_PACKER_STATS_EN for pkt/err counters.
module crossfile_packer
  import crossfile_pkg::*;
#(
  parameter int DEPTH  = crossfile_pkg::FIFO_DEPTH,
  parameter int BEAT_W = PACKER_BEAT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BEAT_W-1:0]             in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  output transaction_t                  out_trans,
  input  logic                          credit_ret,
  output logic [$clog2(DEPTH+1)-1:0]    credits,
  output logic                          err_len
`ifdef CROSSFILE_PACKER_STATS_EN
  ,
  output logic [15:0]                   pkt_count,
  output logic [7:0]                    err_count
`endif
);

  localparam int TRANS_W = $bits(transaction_t);
  localparam int NBEATS  = calc_beats(TRANS_W, BEAT_W);
  localparam int CNT_W   = $clog2(NBEATS + 1);

  packer_state_e      state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic [TRANS_W-1:0] asm_q;
  transaction_t       last_q;

  logic beat;
  logic filling;
  logic is_last_slot;
  logic emit;

  // Reset wins over any beat presented in the same cycle.
  assign beat         = in_valid && in_ready && !rst;
  assign filling      = (state_q == IDLE) || (state_q == FILL);
  assign is_last_slot = (beat_cnt_q == CNT_W'(NBEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FILL: begin
        if (beat) begin
          if (is_last_slot)  state_d = in_last ? EMIT : DRAIN;
          else if (in_last)  state_d = IDLE;
          else               state_d = FILL;
        end
      end
      EMIT:    if (credits != '0) state_d = IDLE;
      DRAIN:   if (beat && in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    in_ready  = 1'b0;
    emit      = 1'b0;
    err_len   = 1'b0;
    in_ready  = (state_q != EMIT);
    emit      = (state_q == EMIT) && (credits != '0) && !rst;
    err_len   = beat && filling && (is_last_slot ? !in_last : in_last);
  end

  assign out_valid = emit;
  // The pending transaction appears only on its strobe; otherwise the last one emitted.
  assign out_trans = emit ? transaction_t'(asm_q) : last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      asm_q      <= '0;
      last_q     <= '0;
    end else begin
      if (state_d != FILL)  beat_cnt_q <= '0;
      else if (beat)        beat_cnt_q <= beat_cnt_q + 1'b1;

      if (err_len) begin
        asm_q <= '0;
      end else if (beat && filling) begin
        // Bits of the final beat that fall above TRANS_W have no home and are dropped.
        for (int i = 0; i < TRANS_W; i++) begin
          if (i / BEAT_W == int'(beat_cnt_q)) asm_q[i] <= in_data[i % BEAT_W];
        end
      end

      if (emit) last_q <= transaction_t'(asm_q);
    end
  end

  crossfile_credit_ctr #(
    .MAX (DEPTH)
  ) u_credit_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (credit_ret),
    .dec   (emit),
    .count (credits)
  );

`ifdef CROSSFILE_PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (out_valid) pkt_count <= pkt_count + 16'd1;
      if (err_len && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crossfile_packer.sv
// Self-checking bench for crossfile_packer: directed scenarios plus randomized
// traffic checked against a transaction-level model of packing and credits.
`timescale 1ns/1ps
module tb_crossfile_packer;

  localparam int TW    = $bits(crossfile_pkg::transaction_t);
  localparam int NB    = (TW + 7) / 8;
  localparam int DEPTH = crossfile_pkg::FIFO_DEPTH;
  localparam int CRW   = $clog2(DEPTH + 1);

  typedef logic [7:0] beat_arr_t [NB];

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         in_valid = 1'b0;
  logic                         in_ready;
  logic [7:0]                   in_data = '0;
  logic                         in_last = 1'b0;
  logic                         out_valid;
  crossfile_pkg::transaction_t  out_trans;
  logic                         credit_ret = 1'b0;
  logic [CRW-1:0]               credits;
  logic                         err_len;
`ifdef CROSSFILE_PACKER_STATS_EN
  logic [15:0]                  pkt_count;
  logic [7:0]                   err_count;
`endif

  crossfile_packer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_trans  (out_trans),
    .credit_ret (credit_ret),
    .credits    (credits),
    .err_len    (err_len)
`ifdef CROSSFILE_PACKER_STATS_EN
    ,
    .pkt_count  (pkt_count),
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_pulse = 0;
  int n_err = 0;

  always @(negedge clk) begin
    if (out_valid) n_pulse++;
    if (err_len)   n_err++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Expected transaction: beat k contributes its byte at weight 256^k, truncated to TW bits.
  function automatic logic [TW-1:0] pack(input beat_arr_t b);
    logic [63:0] acc;
    acc = '0;
    for (int k = 0; k < NB; k++) acc = acc | (64'(b[k]) << (8 * k));
    return acc[TW-1:0];
  endfunction

  function automatic beat_arr_t rand_beats();
    beat_arr_t b;
    for (int k = 0; k < NB; k++) b[k] = 8'($urandom);
    return b;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic l, output logic err_seen);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    err_seen = err_len;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_clean(input beat_arr_t b);
    logic e;
    for (int k = 0; k < NB; k++) drive_beat(b[k], (k == NB - 1), e);
  endtask

  task automatic return_credit();
    credit_ret = 1'b1;
    cyc();
    credit_ret = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL reset_err_len: got %b expected 0", err_len); end
    checks++; if (credits !== CRW'(DEPTH)) begin errors++; $display("FAIL reset_credits: got %0d expected %0d", credits, DEPTH); end
    checks++; if (out_trans !== '0) begin errors++; $display("FAIL reset_out_trans: got %h expected 0", out_trans); end
  endtask

  task automatic test_basic();
    beat_arr_t b;
    logic [TW-1:0] exp;
    int n0;
    for (int k = 0; k < NB; k++) b[k] = 8'(k + 1);
    exp = pack(b);
    n0 = n_pulse;
    send_clean(b);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got out_valid=%b expected 1", out_valid); end
    checks++; if (out_trans !== exp) begin errors++; $display("FAIL basic_trans: got %h expected %h", out_trans, exp); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_emit: got %b expected 0", in_ready); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %b expected 0", out_valid); end
    checks++; if (credits !== CRW'(DEPTH - 1)) begin errors++; $display("FAIL basic_credits: got %0d expected %0d", credits, DEPTH - 1); end
    checks++; if (out_trans !== exp) begin errors++; $display("FAIL basic_hold: got %h expected %h", out_trans, exp); end
    checks++; if (n_pulse - n0 != 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", n_pulse - n0); end
  endtask

  task automatic test_back_to_back();
    beat_arr_t b;
    logic [TW-1:0] exp, prev;
    int n0;
    return_credit();
    checks++; if (credits !== CRW'(DEPTH)) begin errors++; $display("FAIL b2b_start_credits: got %0d expected %0d", credits, DEPTH); end
    n0 = n_pulse;
    prev = '0;
    for (int i = 0; i < DEPTH; i++) begin
      b = rand_beats();
      exp = pack(b);
      send_clean(b);
      checks++; if (out_valid !== 1'b1 || out_trans !== exp) begin errors++; $display("FAIL b2b_emit%0d: got valid=%b trans=%h expected valid=1 trans=%h", i, out_valid, out_trans, exp); end
      prev = exp;
      cyc();
    end
    checks++; if (n_pulse - n0 != DEPTH) begin errors++; $display("FAIL b2b_pulses: got %0d expected %0d", n_pulse - n0, DEPTH); end
    checks++; if (credits !== '0) begin errors++; $display("FAIL b2b_empty: got %0d expected 0", credits); end
    b = rand_beats();
    exp = pack(b);
    send_clean(b);
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_trans !== prev) begin errors++; $display("FAIL b2b_stall%0d: got valid=%b ready=%b trans=%h expected 0 0 %h", i, out_valid, in_ready, out_trans, prev); end
      cyc();
    end
    return_credit();
    checks++; if (out_valid !== 1'b1 || out_trans !== exp) begin errors++; $display("FAIL b2b_release: got valid=%b trans=%h expected valid=1 trans=%h", out_valid, out_trans, exp); end
    cyc();
    checks++; if (credits !== '0) begin errors++; $display("FAIL b2b_after_release: got %0d expected 0", credits); end
    credit_ret = 1'b1;
    repeat (DEPTH) cyc();
    credit_ret = 1'b0;
    checks++; if (credits !== CRW'(DEPTH)) begin errors++; $display("FAIL b2b_refill: got %0d expected %0d", credits, DEPTH); end
  endtask

  task automatic test_early_last();
    beat_arr_t b;
    logic [TW-1:0] exp;
    logic e;
    int n0, e0;
    n0 = n_pulse;
    e0 = n_err;
    drive_beat(8'($urandom), 1'b0, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL early_beat0_err: got %b expected 0", e); end
    drive_beat(8'($urandom), 1'b1, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL early_err_pulse: got %b expected 1", e); end
    cyc();
    checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL early_err_once: got %0d expected 1", n_err - e0); end
    checks++; if (n_pulse != n0) begin errors++; $display("FAIL early_no_emit: got %0d pulses expected 0", n_pulse - n0); end
    b = rand_beats();
    exp = pack(b);
    send_clean(b);
    checks++; if (out_valid !== 1'b1 || out_trans !== exp) begin errors++; $display("FAIL early_recover: got valid=%b trans=%h expected valid=1 trans=%h", out_valid, out_trans, exp); end
    cyc();
    return_credit();
  endtask

  task automatic test_missing_last();
    beat_arr_t b;
    logic [TW-1:0] exp;
    logic e;
    int n0, e0;
    n0 = n_pulse;
    e0 = n_err;
    for (int k = 0; k < NB; k++) begin
      drive_beat(8'($urandom), 1'b0, e);
      checks++; if (e !== (k == NB - 1)) begin errors++; $display("FAIL missing_err_beat%0d: got %b expected %b", k, e, (k == NB - 1)); end
    end
    for (int j = 0; j < 3; j++) begin
      drive_beat(8'($urandom), (j == 2), e);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL missing_drain%0d: got err=%b expected 0", j, e); end
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL missing_idle_ready: got %b expected 1", in_ready); end
    checks++; if (n_err - e0 != 1 || n_pulse != n0) begin errors++; $display("FAIL missing_counts: got err=%0d pulses=%0d expected 1 0", n_err - e0, n_pulse - n0); end
    b = rand_beats();
    exp = pack(b);
    send_clean(b);
    checks++; if (out_valid !== 1'b1 || out_trans !== exp) begin errors++; $display("FAIL missing_recover: got valid=%b trans=%h expected valid=1 trans=%h", out_valid, out_trans, exp); end
    cyc();
    return_credit();
  endtask

  task automatic test_credit_same_cycle();
    credit_ret = 1'b1;
    repeat (2) cyc();
    credit_ret = 1'b0;
    checks++; if (credits !== CRW'(DEPTH)) begin errors++; $display("FAIL credit_saturate: got %0d expected %0d", credits, DEPTH); end
    send_clean(rand_beats());
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL credit_emit_full: got %b expected 1", out_valid); end
    return_credit();
    checks++; if (credits !== CRW'(DEPTH)) begin errors++; $display("FAIL credit_same_full: got %0d expected %0d", credits, DEPTH); end
    send_clean(rand_beats());
    cyc();
    checks++; if (credits !== CRW'(DEPTH - 1)) begin errors++; $display("FAIL credit_dec: got %0d expected %0d", credits, DEPTH - 1); end
    send_clean(rand_beats());
    return_credit();
    checks++; if (credits !== CRW'(DEPTH - 1)) begin errors++; $display("FAIL credit_same_partial: got %0d expected %0d", credits, DEPTH - 1); end
    return_credit();
  endtask

  task automatic test_reset_mid();
    logic e;
    int n0;
    n0 = n_pulse;
    drive_beat(8'($urandom), 1'b0, e);
    drive_beat(8'($urandom), 1'b0, e);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++; if (credits !== CRW'(DEPTH) || in_ready !== 1'b1 || out_trans !== '0) begin errors++; $display("FAIL rstmid_state: got credits=%0d ready=%b trans=%h expected %0d 1 0", credits, in_ready, out_trans, DEPTH); end
    send_clean(rand_beats());
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstemit_valid: got %b expected 0", out_valid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) cyc();
    checks++; if (n_pulse != n0) begin errors++; $display("FAIL rstmid_no_emit: got %0d pulses expected 0", n_pulse - n0); end
    checks++; if (credits !== CRW'(DEPTH)) begin errors++; $display("FAIL rstemit_credits: got %0d expected %0d", credits, DEPTH); end
`ifdef CROSSFILE_PACKER_STATS_EN
    checks++; if (pkt_count !== 16'd0 || err_count !== 8'd0) begin errors++; $display("FAIL rstmid_stats: got pkt=%0d err=%0d expected 0 0", pkt_count, err_count); end
`endif
  endtask

  task automatic test_random();
    beat_arr_t b;
    logic [TW-1:0] exp;
    logic cr, ov, emitted;
    logic [TW-1:0] ot;
    int exp_cred;
    int emits;
    exp_cred = DEPTH;
    emits = 0;
    for (int it = 0; it < 40; it++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        credit_ret = ($urandom_range(0, 2) == 0);
        cyc();
        if (credit_ret && exp_cred < DEPTH) exp_cred++;
        credit_ret = 1'b0;
      end
      b = rand_beats();
      exp = pack(b);
      send_clean(b);
      emitted = 1'b0;
      for (int w = 0; w < 20 && !emitted; w++) begin
        if (exp_cred == 0) cr = (w >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        else               cr = ($urandom_range(0, 3) == 0);
        credit_ret = cr;
        @(negedge clk);
        ov = out_valid;
        ot = out_trans;
        @(posedge clk);
        #1;
        credit_ret = 1'b0;
        checks++; if (ov !== (exp_cred > 0)) begin errors++; $display("FAIL rand%0d_valid_w%0d: got %b expected %b", it, w, ov, (exp_cred > 0)); end
        if (exp_cred > 0) begin
          checks++; if (ot !== exp) begin errors++; $display("FAIL rand%0d_trans: got %h expected %h", it, ot, exp); end
          emitted = 1'b1;
          emits++;
          if (!cr) exp_cred--;
        end else if (cr) begin
          exp_cred++;
        end
      end
      if (!emitted) begin
        checks++; errors++;
        $display("FAIL rand%0d_timeout: got no emit expected emit within 20 cycles", it);
      end
      checks++; if (credits !== CRW'(exp_cred)) begin errors++; $display("FAIL rand%0d_credits: got %0d expected %0d", it, credits, exp_cred); end
    end
`ifdef CROSSFILE_PACKER_STATS_EN
    checks++; if (pkt_count !== 16'(emits) || err_count !== 8'd0) begin errors++; $display("FAIL rand_stats: got pkt=%0d err=%0d expected %0d 0", pkt_count, err_count, emits); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_early_last();
    test_missing_last();
    test_credit_same_cycle();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
